peripheral_wb_burst_ram_bb: RTL and testbench

- Wishbone B3 slave memory model that consumes the transactions produced by the Wishbone BFM master in the GPIO bench.
- Supports classic cycles, constant-address bursts and incrementing bursts (CTI/BTE), byte selects and programmable wait states.
- Sits on the bench bus in place of, or beside, the GPIO register file, so master burst and compare tasks can be checked against a known-good target.

---
 rtl/peripheral_wb_burst_ram_bb.sv | 188 ++++++++++++++++++
 tb/tb_peripheral_wb_burst_ram_bb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_wb_burst_ram_bb.sv
// Wishbone B3 burst-capable RAM slave: classic, constant and incrementing (linear/wrap) bursts.
// Optional out-of-range error responses are enabled with `define PERIPHERAL_BB_RAM_ERR_EN.
module peripheral_wb_burst_ram_bb #(
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter int              DEPTH       = 256,
  parameter int              WAIT_STATES = 0,
  parameter logic [DW-1:0]   MEM_INIT    = '0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o
);

  localparam int         SW        = DW / 8;
  localparam int         ADR_LSB   = $clog2(SW);
  localparam int         IW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);
  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;
  localparam logic [2:0] CTI_END   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SINGLE, S_BURST} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [IW-1:0]   r_idx;
  logic [2:0]      r_cti;
  logic            r_oor;
  logic            r_ack;
  logic            r_err;
  logic [DW-1:0]   r_dat;
  logic [DW-1:0]   r_mem [DEPTH] = '{default: MEM_INIT};

  logic [IW-1:0]   w_idx_in;
  logic [IW-1:0]   w_mask;
  logic [IW-1:0]   w_next_idx;
  logic            w_oor_in;
  logic            w_next_oor;
  logic            w_resp;
  logic            w_commit;
  logic [DW-1:0]   w_wr_data;
  logic [DW-1:0]   w_next_dat;
  logic            w_unused;

  function automatic logic is_burst(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

  assign w_idx_in = wb_adr_i[ADR_LSB +: IW];
  assign w_resp   = r_ack | r_err;
  assign w_commit = wb_cyc_i & wb_stb_i & wb_we_i & r_ack &
                    ((r_state == S_SINGLE) | (r_state == S_BURST));
  assign w_unused = ^{wb_adr_i[ADR_LSB-1:0], wb_adr_i[AW-1:ADR_LSB+IW]};

`ifdef PERIPHERAL_BB_RAM_ERR_EN
  assign w_oor_in   = |wb_adr_i[AW-1:ADR_LSB+IW];
  // Only a linear burst stepping past the last word can leave the array mid-burst.
  assign w_next_oor = (wb_bte_i == 2'b00) && (wb_cti_i != CTI_CONST) && (&r_idx);
`else
  assign w_oor_in   = 1'b0;
  assign w_next_oor = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_wr_data = r_mem[r_idx];
    for (int b = 0; b < SW; b++) begin
      if (wb_sel_i[b]) w_wr_data[8*b +: 8] = wb_dat_i[8*b +: 8];
    end

    case (wb_bte_i)
      2'b01:   w_mask = IW'(3);
      2'b10:   w_mask = IW'(7);
      2'b11:   w_mask = IW'(15);
      default: w_mask = '1;
    endcase

    if (wb_cti_i == CTI_CONST) w_next_idx = r_idx;
    else                       w_next_idx = (r_idx & ~w_mask) | ((r_idx + IW'(1)) & w_mask);

    w_next_dat = (w_commit && (w_next_idx == r_idx)) ? w_wr_data : r_mem[w_next_idx];
  end

  // NOTE: the memory array has no reset; it is initialised once and writes are simply blocked during reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && w_commit) r_mem[r_idx] <= w_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_cti   <= '0;
      r_oor   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            r_idx <= w_idx_in;
            r_cti <= wb_cti_i;
            r_oor <= w_oor_in;
            r_dat <= r_mem[w_idx_in];
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LOAD;
            end else begin
              r_state <= is_burst(wb_cti_i) ? S_BURST : S_SINGLE;
              r_ack   <= !w_oor_in;
              r_err   <= w_oor_in;
            end
          end
        end

        S_WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= is_burst(r_cti) ? S_BURST : S_SINGLE;
            r_ack   <= !r_oor;
            r_err   <= r_oor;
            r_dat   <= r_mem[r_idx];
          end
        end

        S_SINGLE: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end

        S_BURST: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
          end else if (!wb_stb_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
          end else if (!w_resp) begin
            // Master returned from a stall: respond at once with the held address.
            r_ack <= !r_oor;
            r_err <= r_oor;
            r_dat <= r_mem[r_idx];
          end else if (r_err || (wb_cti_i == CTI_END)) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
          end else begin
            r_idx <= w_next_idx;
            r_oor <= w_next_oor;
            r_dat <= w_next_dat;
            r_ack <= !w_next_oor;
            r_err <= w_next_oor;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_peripheral_wb_burst_ram_bb.sv
// Scoreboard bench for peripheral_wb_burst_ram_bb: zero-wait and three-wait-state instances share one bus.
// Read expectations are queued when a beat is driven and popped when the slave acknowledges it.
module tb_peripheral_wb_burst_ram_bb;

`ifdef PERIPHERAL_BB_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [2:0] INCR  = 3'b010;
  localparam logic [2:0] CONST = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc0 = 1'b0;
  logic        cyc1 = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;

  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1, rty0, rty1;
  int          dsel = 0;
  logic [31:0] m_dat;
  logic        m_ack, m_err;

  assign m_dat = (dsel == 1) ? dat1 : dat0;
  assign m_ack = (dsel == 1) ? ack1 : ack0;
  assign m_err = (dsel == 1) ? err1 : err0;

  logic [31:0] model [2][256];
  logic [31:0] sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  peripheral_wb_burst_ram_bb #(.WAIT_STATES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0)
  );

  peripheral_wb_burst_ram_bb #(.WAIT_STATES(3)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(input int idx, input logic [2:0] c, input logic [1:0] b);
    int m;
    if (c == CONST) return idx;
    case (b)
      2'b00:   return (idx + 1) % 256;
      2'b01:   m = 4;
      2'b10:   m = 8;
      default: m = 16;
    endcase
    return (idx / m) * m + ((idx + 1) % m);
  endfunction

  task automatic set_cyc(input int d, input logic v);
    if (d == 1) cyc1 = v;
    else        cyc0 = v;
  endtask

  // One classic cycle; latency and ack/err choice are derived from the instance and address.
  task automatic classic(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
    int          n;
    int          idx;
    logic        oor;
    logic [31:0] exp;
    oor = ERR_EN && (a >= 32'd1024);
    idx = int'(a[9:2]);
    dsel = d;
    set_cyc(d, 1'b1);
    stb = 1'b1; we = w; adr = a; dat_w = wd; sel = s; cti = 3'b000; bte = 2'b00;
    if (!w) sb.push_back(model[d][idx]);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(m_ack || m_err) && n < 40);
    check("classic_latency", n, (d == 1) ? 4 : 1);
    check("classic_err", m_err, oor);
    check("classic_ack", m_ack, !oor);
    if (!w) begin
      exp = sb.pop_front();
      if (!oor) check("classic_rdata", m_dat, exp);
    end
    @(posedge clk); #1;
    if (w && !oor) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
    set_cyc(d, 1'b0);
    stb = 1'b0; we = 1'b0;
    check("classic_ack_drop", m_ack | m_err, 1'b0);
  endtask

  // Burst of n beats; optional master stall before beat stall_at and reset during beat rst_at.
  task automatic burst(input int d, input logic w, input logic [31:0] a, input int n,
                       input logic [2:0] mode, input logic [1:0] b, input logic [31:0] base,
                       input int stall_at, input int rst_at, input int exp_low);
    int   idx, beat, lows, stall_left;
    logic seen, hit, aborted;
    idx = int'(a[9:2]);
    beat = 0; lows = 0; stall_left = 0; seen = 1'b0; aborted = 1'b0;
    dsel = d;
    set_cyc(d, 1'b1);
    stb = 1'b1; we = w; adr = a; sel = 4'hF; bte = b;
    cti = (n == 1) ? 3'b111 : mode;
    dat_w = base;
    if (!w) sb.push_back(model[d][idx]);
    for (int t = 0; t < 300 && beat < n && !aborted; t++) begin
      @(negedge clk);
      hit = m_ack && stb;
      if (m_ack) seen = 1'b1;
      else if (seen) lows++;
      if (hit && !w) check("burst_rdata", m_dat, sb.pop_front());
      if (hit && beat == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_ack", m_ack, 1'b0);
        check("rst_err", m_err, 1'b0);
        check("rst_dat", m_dat, 32'h0);
        set_cyc(d, 1'b0);
        stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (hit) begin
          if (w) model[d][idx] = dat_w;
          beat++;
          idx = nxt(idx, cti, b);
          if (beat < n) begin
            cti = (beat == n - 1) ? 3'b111 : mode;
            dat_w = base + 32'(beat);
            if (!w) sb.push_back(model[d][idx]);
          end
        end
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) stb = 1'b1;
        end else if (hit && beat == stall_at) begin
          stb = 1'b0;
          stall_left = 2;
        end
      end
    end
    if (!aborted) begin
      check("burst_beats", beat, n);
      check("burst_end_ack", m_ack, 1'b0);
      check("burst_ack_low_cycles", lows, exp_low);
    end
    set_cyc(d, 1'b0);
    stb = 1'b0; we = 1'b0; cti = 3'b000;
    sb.delete();
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) model[d][i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", ack0, 1'b0);
    check("reset_err", err0, 1'b0);
    check("reset_rty", rty0, 1'b0);
    check("reset_dat", dat0, 32'h0);
    check("reset_ack_ws", ack1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    classic(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    classic(0, 1'b0, 32'h10, 32'h0, 4'hF);

    classic(0, 1'b1, 32'h14, 32'h11223344, 4'hF);
    classic(0, 1'b1, 32'h14, 32'h000000AA, 4'b0001);
    classic(0, 1'b0, 32'h14, 32'h0, 4'hF);
    check("bytesel_model", model[0][5], 32'h112233AA);

    burst(0, 1'b1, 32'h20, 8, INCR, 2'b00, 32'h0, -1, -1, 0);
    burst(0, 1'b0, 32'h20, 8, INCR, 2'b00, 32'h0, -1, -1, 0);

    burst(0, 1'b0, 32'h38, 4, INCR, 2'b01, 32'h0, -1, -1, 0);
    burst(0, 1'b0, 32'h3C, 3, INCR, 2'b10, 32'h0, -1, -1, 0);

    burst(0, 1'b1, 32'h60, 3, CONST, 2'b00, 32'h11, -1, -1, 0);
    classic(0, 1'b0, 32'h60, 32'h0, 4'hF);
    classic(0, 1'b0, 32'h64, 32'h0, 4'hF);

    classic(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    classic(1, 1'b0, 32'h40, 32'h0, 4'hF);
    burst(1, 1'b1, 32'h80, 6, INCR, 2'b00, 32'h100, -1, -1, 0);
    burst(1, 1'b0, 32'h80, 6, INCR, 2'b00, 32'h0, 3, -1, 2);

    classic(0, 1'b1, 32'h400, 32'h55AA55AA, 4'hF);
    classic(0, 1'b0, 32'h0, 32'h0, 4'hF);
`ifndef PERIPHERAL_BB_RAM_ERR_EN
    burst(0, 1'b0, 32'h3F8, 3, INCR, 2'b00, 32'h0, -1, -1, 0);
`endif

    burst(0, 1'b1, 32'hC0, 4, INCR, 2'b00, 32'hA0, -1, 2, 0);
    for (int i = 0; i < 4; i++) classic(0, 1'b0, 32'hC0 + 32'(4 * i), 32'h0, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
